// File: rtl/memory_unit.sv
// Single-port word memory with one-cycle registered read and access error flagging.
// Optional post-reset clear sweep enabled by defining MEM_CLEAR_ON_RESET_EN.
module memory_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 2048
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memoryRead,
  input  logic                  memoryWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] memoryData,
  output logic                  ready,
  output logic                  accessError
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  serve, addr_ok, rd_only, wr_ok;
  logic [IDX_W-1:0]      addr_idx;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  // Request decode: only a settled IDLE state with ready high accepts requests.
  always_comb begin
    serve    = (state_q == ST_IDLE) && ready_q;
    addr_ok  = in_range(address);
    addr_idx = address[IDX_W-1:0];
    rd_only  = memoryRead && !memoryWrite;
    wr_ok    = serve && memoryWrite && addr_ok;
    err_d    = serve && ((memoryRead && memoryWrite) ||
                         ((memoryRead || memoryWrite) && !addr_ok));
    rdata_d  = rdata_q;
    if (serve && rd_only) begin
      rdata_d = addr_ok ? mem[addr_idx] : '0;
    end
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  assign clr_cnt_d = (clr_cnt_q == LAST_IDX) ? '0 : clr_cnt_q + IDX_W'(1);

  // The clear sweep owns the write port while in INIT.
  always_comb begin
    mem_we    = wr_ok;
    mem_idx   = addr_idx;
    mem_wdata = writeData;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q;
      mem_wdata = '0;
    end
  end
`else
  always_comb begin
    mem_we    = wr_ok;
    mem_idx   = addr_idx;
    mem_wdata = writeData;
  end
`endif

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
`ifdef MEM_CLEAR_ON_RESET_EN
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
`else
      state_q   <= ST_IDLE;
`endif
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      case (state_q)
        ST_INIT: begin
`ifdef MEM_CLEAR_ON_RESET_EN
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
`else
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
`endif
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  assign memoryData  = rdata_q;
  assign ready       = ready_q;
  assign accessError = err_q;

endmodule
